// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: WIDTH steps per operation,
// holds the pipeline via stall_o, delivers {remainder, quotient}.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  dvd;      // dividend, quotient bits shift in from the right
    logic [WIDTH-1:0]  dvs;
    logic [WIDTH-1:0]  rem;
    logic              q_neg, r_neg;

    logic [WIDTH:0]    rem_sh, diff;
    logic [WIDTH-1:0]  step_rem, step_q;
    logic [WIDTH-1:0]  abs1, abs2, fix_q, fix_r;
    logic              last_step;

    // Absolute values of the incoming operands (only for signed division)
    always_comb begin
        abs1 = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        abs2 = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    end

    // One restoring step plus the sign fix applied on the final step
    always_comb begin
        rem_sh    = {rem, dvd[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvs};
        step_rem  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        step_q    = {dvd[WIDTH-2:0], ~diff[WIDTH]};
        fix_q     = q_neg ? (~step_q + WIDTH'(1)) : step_q;
        fix_r     = r_neg ? (~step_rem + WIDTH'(1)) : step_rem;
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; annul overrides every other transition
    always_comb begin
        state_next = state;
        if (annul_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_next = (opdata2_i == '0) ? BYZERO : ON;
                BYZERO:  state_next = FINISH;
                ON:      if (last_step) state_next = FINISH;
                FINISH:  if (!start_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, result and ready registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= (state_next == FINISH);
            if (!annul_i) begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            dvd   <= abs1;
                            dvs   <= abs2;
                            rem   <= '0;
                            cnt   <= '0;
                            q_neg <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg <= signed_i & opdata1_i[WIDTH-1];
                        end
                    end
                    BYZERO: result_o <= '0;
                    ON: begin
                        dvd <= step_q;
                        rem <= step_rem;
                        cnt <= cnt + CW'(1);
                        if (last_step) result_o <= {fix_r, fix_q};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stall the pipeline while a requested division has not yet delivered
    assign stall_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, arithmetic corner cases, annul,
// asynchronous reset and back-to-back operation.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Run one division starting at the current negedge (state IDLE). Returns
    // at the negedge after start was dropped, with the unit back in IDLE.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat, input bit scramble);
        int lat;
        bit stall_bad;
        logic [63:0] held;
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        stall_bad = (stall_o !== 1'b1);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                lat = c;
                break;
            end
            if (stall_o !== 1'b1) stall_bad = 1'b1;
            if (scramble) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        chk({tag, "_stall_ready"}, 64'(stall_o), 64'd0);
        held = result_o;
        repeat (2) @(negedge clk);
        chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_result"}, result_o, held);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_clear"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", 64'(stall_o), 64'd0);
        chk("idle_ready", 64'(ready_o), 64'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0);
        run_div("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 1'b0);
        run_div("divzero", 1'b0, 32'h1234, 32'd0, 64'd0, 2, 1'b0);
        run_div("scramble", 1'b0, 32'd1003, 32'd10, {32'd3, 32'd100}, 33, 1'b1);

        // Annul in cycle 10: no result, previous result kept, restart works
        begin
            bit rdy_seen;
            rdy_seen  = 1'b0;
            start_i   = 1'b1;
            signed_i  = 1'b0;
            opdata1_i = 32'd50;
            opdata2_i = 32'd3;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (ready_o) rdy_seen = 1'b1;
            end
            annul_i = 1'b1;
            #1;
            chk("annul_stall", 64'(stall_o), 64'd0);
            @(negedge clk);
            annul_i = 1'b0;
            if (ready_o) rdy_seen = 1'b1;
            chk("annul_no_ready", 64'(rdy_seen), 64'd0);
            chk("annul_result_kept", result_o, {32'd3, 32'd100});
            run_div("after_annul", 1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 33, 1'b0);
        end

        // Asynchronous reset between edges while ON
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result_o, 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_div("post_rst", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);

        // Back-to-back with a single start-low cycle in between
        run_div("b2b_a", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0);
        run_div("b2b_b", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
